// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/window types, default image geometry and window slot indices.
package sobel_pkg;
    localparam int PIXEL_W    = 8;
    localparam int IMG_WIDTH  = 128;
    localparam int IMG_HEIGHT = 128;

    // Slot index inside the packed window; p00 sits in the MSBs.
    localparam int P00 = 8;
    localparam int P01 = 7;
    localparam int P02 = 6;
    localparam int P10 = 5;
    localparam int P11 = 4;
    localparam int P12 = 3;
    localparam int P20 = 2;
    localparam int P21 = 1;
    localparam int P22 = 0;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef pixel_t [8:0] window_t;
    typedef enum logic {FILL, STREAM} state_e;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one row of pixels addressed by column; the read returns the old word at the written address.
module line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/gray_window_3x3.sv
// gray_window_3x3: turns a raster grayscale stream into registered 3x3 neighbourhoods,
// one clock after the pixel that completes each window, with row/col and end-of-frame tags.
module gray_window_3x3 #(
    parameter int IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
    parameter int PIXEL_W    = sobel_pkg::PIXEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIXEL_W-1:0]            gray_i,
    input  logic                          gray_valid_i,
    output logic [9*PIXEL_W-1:0]          window_o,
    output logic                          window_valid_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic                          frame_done_o
);
    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]                   row_q, row_d, orow_q, orow_d;
    logic                            wv_q, wv_d, fd_q, fd_d;
    logic [2:0][1:0][PIXEL_W-1:0]    tap_q, tap_d;
    logic [8:0][PIXEL_W-1:0]         win_q, win_d, win_new;
    logic [2:0][PIXEL_W-1:0]         cur;
    logic [PIXEL_W-1:0]              lb0_rd, lb1_rd;
    logic                            last_col, last_row, emit;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb1 (
        .clk     (clk),
        .we_i    (gray_valid_i),
        .addr_i  (col_q),
        .wdata_i (gray_i),
        .rdata_o (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb0 (
        .clk     (clk),
        .we_i    (gray_valid_i),
        .addr_i  (col_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    assign last_col = col_q == CW'(IMG_WIDTH - 1);
    assign last_row = row_q == RW'(IMG_HEIGHT - 1);
    assign emit     = gray_valid_i && state_q == STREAM && col_q >= CW'(2);

    always_comb begin
        state_d = state_q;
        if (gray_valid_i && last_col && state_q == FILL && row_q == RW'(1)) state_d = STREAM;
        if (gray_valid_i && last_col && state_q == STREAM && last_row) state_d = FILL;
    end

    always_comb begin
        col_d = gray_valid_i ? (last_col ? '0 : col_q + 1'b1) : col_q;
        row_d = (gray_valid_i && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
        cur   = {gray_i, lb1_rd, lb0_rd};
        tap_d = tap_q;
        for (int r = 0; r < 3; r++) begin
            if (gray_valid_i) tap_d[r] = {cur[r], tap_q[r][1]};
        end
        // Columns col-2 and col-1 come from the taps, column col straight from the buffers/input.
        win_new      = '0;
        win_new[P00] = tap_q[0][0];
        win_new[P01] = tap_q[0][1];
        win_new[P02] = lb0_rd;
        win_new[P10] = tap_q[1][0];
        win_new[P11] = tap_q[1][1];
        win_new[P12] = lb1_rd;
        win_new[P20] = tap_q[2][0];
        win_new[P21] = tap_q[2][1];
        win_new[P22] = gray_i;
        win_d  = emit ? win_new : win_q;
        orow_d = emit ? row_q : orow_q;
        ocol_d = emit ? col_q : ocol_q;
        wv_d   = emit;
        fd_d   = emit && last_row && last_col;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            wv_q    <= 1'b0;
            fd_q    <= 1'b0;
            tap_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            wv_q    <= wv_d;
            fd_q    <= fd_d;
            tap_q   <= tap_d;
            win_q   <= win_d;
        end
    end

    assign window_o       = win_q;
    assign window_valid_o = wv_q;
    assign row_o          = orow_q;
    assign col_o          = ocol_q;
    assign frame_done_o   = fd_q;
endmodule

// File: tb/tb_gray_window_3x3.sv
// tb_gray_window_3x3: 4x4 and 128x128 instances checked every cycle against an image-array reference.
module tb_gray_window_3x3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] a_gray = '0, b_gray = '0;
    logic a_vld = 1'b0, b_vld = 1'b0;
    logic [71:0] a_win, b_win;
    logic a_wv, b_wv, a_fd, b_fd;
    logic [1:0] a_row, a_col;
    logic [6:0] b_row, b_col;

    always #5 clk = ~clk;

    gray_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_W(8)) dut_a (
        .clk(clk), .rst(rst), .gray_i(a_gray), .gray_valid_i(a_vld),
        .window_o(a_win), .window_valid_o(a_wv), .row_o(a_row), .col_o(a_col),
        .frame_done_o(a_fd)
    );

    gray_window_3x3 dut_b (
        .clk(clk), .rst(rst), .gray_i(b_gray), .gray_valid_i(b_vld),
        .window_o(b_win), .window_valid_o(b_wv), .row_o(b_row), .col_o(b_col),
        .frame_done_o(b_fd)
    );

    typedef struct {logic [71:0] w; int r; int c; logic fd;} rec_t;

    int total = 0, bad = 0;
    int mr[2], mc[2];
    int wh[2] = '{4, 128};
    logic ev[2], efd[2];
    logic [71:0] ewin[2];
    int erow[2], ecol[2];
    logic [7:0] img [2][128][128];
    rec_t lg[$], clean[$];
    int nwin_b = 0, nfd_b = 0;
    logic [71:0] cap_b = '0;

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h need %h", nm, got, exp);
        end
    endtask

    // Reference: store the frame as an image and read the 3x3 neighbourhood directly from it.
    task automatic model(input int d, input logic v, input logic [7:0] p);
        ev[d]  = 1'b0;
        efd[d] = 1'b0;
        if (v) begin
            img[d][mr[d]][mc[d]] = p;
            if (mr[d] >= 2 && mc[d] >= 2) begin
                ev[d]   = 1'b1;
                erow[d] = mr[d];
                ecol[d] = mc[d];
                efd[d]  = mr[d] == wh[d] - 1 && mc[d] == wh[d] - 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ewin[d][(8 - 3 * i - j) * 8 +: 8] = img[d][mr[d] - 2 + i][mc[d] - 2 + j];
            end
            mc[d]++;
            if (mc[d] == wh[d]) begin
                mc[d] = 0;
                mr[d] = (mr[d] + 1 == wh[d]) ? 0 : mr[d] + 1;
            end
        end
    endtask

    task automatic step(input int d, input logic v, input logic [7:0] p);
        a_vld  = d == 0 && v;
        b_vld  = d == 1 && v;
        a_gray = p;
        b_gray = p;
        @(posedge clk);
        model(0, d == 0 && v, p);
        model(1, d == 1 && v, p);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        a_vld = 1'b0;
        b_vld = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mr[d] = 0; mc[d] = 0; ev[d] = 0; efd[d] = 0; ewin[d] = '0; erow[d] = 0; ecol[d] = 0;
        end
        #1;
        chk("rst_out_a", {2'b0, a_win, a_wv, a_fd, a_row, a_col}, '0);
        chk("rst_out_b", {2'b0, b_win[63:0], b_wv, b_fd, b_row, b_col}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // mode: 0 ramp, 1 ramp with toggling/random gaps, 2 constant 255, 3 random pixels and gaps
    task automatic frame(input int d, input int mode, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            int r, c, gaps;
            logic [7:0] p;
            r = k / wh[d];
            c = k % wh[d];
            p = d == 1 ? 8'(r + c) : mode == 2 ? 8'hFF : mode == 3 ? 8'($urandom) : 8'(base + 16 * r + c);
            step(d, 1'b1, p);
            gaps = mode == 1 ? ((k % 2 == 0) ? 1 : int'($urandom_range(0, 3))) :
                   mode == 3 ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) step(d, 1'b0, 8'($urandom));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic gv, gfd;
            logic [71:0] gw;
            int gr, gc;
            gv  = d == 1 ? b_wv : a_wv;
            gfd = d == 1 ? b_fd : a_fd;
            gw  = d == 1 ? b_win : a_win;
            gr  = d == 1 ? int'(b_row) : int'(a_row);
            gc  = d == 1 ? int'(b_col) : int'(a_col);
            total++;
            if (gv !== ev[d] || gfd !== efd[d] || gw !== ewin[d] || gr != erow[d] || gc != ecol[d]) begin
                bad++;
                $display("FAIL cycle dut%0d t=%0t got v=%0b fd=%0b r=%0d c=%0d w=%h need v=%0b fd=%0b r=%0d c=%0d w=%h",
                         d, $time, gv, gfd, gr, gc, gw, ev[d], efd[d], erow[d], ecol[d], ewin[d]);
            end
        end
        if (a_wv) lg.push_back('{a_win, int'(a_row), int'(a_col), a_fd});
        if (b_wv) nwin_b++;
        if (b_fd) nfd_b++;
        if (b_wv && b_row == 7'd127 && b_col == 7'd127) cap_b = b_win;
    end

    initial begin
        do_reset();

        lg.delete();
        frame(0, 0, 8'h00, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("ramp_count", 80'(lg.size()), 80'd4);
        chk("ramp_first_win", 80'(lg[0].w), 80'h000102_101112_202122);
        chk("ramp_first_pos", 80'({lg[0].r, lg[0].c}), 80'({32'd2, 32'd2}));
        chk("ramp_first_fd", 80'(lg[0].fd), 80'd0);
        chk("ramp_last_win", 80'(lg[3].w), 80'h111213_212223_313233);
        chk("ramp_last_fd", 80'(lg[3].fd), 80'd1);
        clean = lg;

        lg.delete();
        frame(0, 1, 8'h00, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("gap_count", 80'(lg.size()), 80'd4);
        for (int i = 0; i < 4; i++) chk("gap_win", 80'(lg[i].w), 80'(clean[i].w));

        frame(0, 0, 8'h00, 6);
        do_reset();
        lg.delete();
        frame(0, 0, 8'h00, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("rst_count", 80'(lg.size()), 80'd4);
        for (int i = 0; i < 4; i++) chk("rst_win", 80'(lg[i].w), 80'(clean[i].w));

        lg.delete();
        frame(0, 0, 8'h00, 16);
        frame(0, 0, 8'h80, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("b2b_count", 80'(lg.size()), 80'd8);
        chk("b2b_second_first", 80'(lg[4].w), 80'h808182_909192_A0A1A2);
        chk("b2b_fd", 80'({lg[3].fd, lg[7].fd, lg[4].fd}), 80'b110);

        lg.delete();
        frame(0, 2, 8'h00, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("ff_count", 80'(lg.size()), 80'd4);
        for (int i = 0; i < 4; i++) chk("ff_win", 80'(lg[i].w), 80'({9{8'hFF}}));

        lg.delete();
        repeat (3) frame(0, 3, 8'h00, 16);
        repeat (2) step(0, 1'b0, 8'h00);
        chk("rand_count", 80'(lg.size()), 80'd12);

        nwin_b = 0;
        nfd_b  = 0;
        frame(1, 0, 8'h00, 128 * 128);
        repeat (2) step(1, 1'b0, 8'h00);
        chk("big_count", 80'(nwin_b), 80'd15876);
        chk("big_fd_count", 80'(nfd_b), 80'd1);
        chk("big_p22", 80'(cap_b[7:0]), 80'hFE);
        chk("big_p02_p20", 80'({cap_b[55:48], cap_b[23:16]}), 80'hFCFC);
        chk("big_p00", 80'(cap_b[71:64]), 80'hFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
